state_dump_reader: RTL and testbench

STATE_DUMP_READER -- requirements
Module: state_dump_reader

---
 rtl/dump_pkg.sv | 20 ++
 rtl/dump_out_stage.sv | 47 ++++
 rtl/state_dump_reader.sv | 133 +++++++++++++
 tb/tb_state_dump_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the state dump reader.
// No logic here; types, tags and widths only.
// Imported by the reader FSM and its output stage.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REGS,
    ST_MEM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic TAG_REG = 1'b0;
  localparam logic TAG_MEM = 1'b1;

  // Width of out_index and of the internal entry counter.
  localparam int IDX_W = 8;

endpackage

// File: rtl/dump_out_stage.sv
// Single output register holding one beat plus its valid/ready handshake.
// Latency: a loaded beat is presented on the cycle after load.
// Backpressure: can_load is high only when empty or the held beat leaves this cycle.
module dump_out_stage
  import dump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_tag,
  input  logic [IDX_W-1:0]  load_index,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tag,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last
);

  // A slot frees up either because it is empty or its beat is taken this edge.
  assign can_load = !out_valid || out_ready;

  // Beat register: load replaces, acceptance without reload empties; fields hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_tag   <= load_tag;
      out_index <= load_index;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/state_dump_reader.sv
// Streams the register file then data memory words 0..DMEM_WORDS-1 as tagged beats.
// Latency: first beat valid two cycles after start; one beat per cycle thereafter.
// Backpressure: out_ready low stalls the walk; the held beat stays stable.
module state_dump_reader
  import dump_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DMEM_WORDS = 64,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [$clog2(NUM_REGS)-1:0] rf_raddr,
  input  logic [DATA_W-1:0]           rf_rdata,
  output logic [31:0]                 dm_raddr,
  input  logic [DATA_W-1:0]           dm_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_tag,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int RA_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DMEM_WORDS - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt, cnt_nxt;
  logic               can_load;
  logic               load;
  logic [DATA_W-1:0]  load_data;
  logic               load_tag;
  logic               load_last;

  // State and entry counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Walk control: fetch one entry whenever the output slot can take it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    load_data = '0;
    load_tag  = TAG_REG;
    load_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_REGS;
          cnt_nxt   = '0;
        end
      end
      ST_REGS: begin
        if (can_load) begin
          load      = 1'b1;
          load_data = rf_rdata;
          load_tag  = TAG_REG;
          if (cnt == LAST_REG) begin
            cnt_nxt   = '0;
            state_nxt = ST_MEM;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_MEM: begin
        if (can_load) begin
          load      = 1'b1;
          load_data = dm_rdata;
          load_tag  = TAG_MEM;
          if (cnt == LAST_WORD) begin
            load_last = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_DRAIN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read addresses are parked at zero whenever their source is not being walked.
  assign rf_raddr = (state == ST_REGS) ? cnt[RA_W-1:0] : '0;
  assign dm_raddr = (state == ST_MEM) ? {{(30 - IDX_W){1'b0}}, cnt, 2'b00} : '0;

  assign busy = (state == ST_REGS) || (state == ST_MEM) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  dump_out_stage #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_tag   (load_tag),
    .load_index (cnt),
    .load_last  (load_last),
    .out_ready  (out_ready),
    .can_load   (can_load),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_index  (out_index),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_state_dump_reader.sv
// Bench for state_dump_reader: memories modelled as arrays, expected beat list built
// from the array contents, beats checked in acceptance order under several ready patterns.
// Also covers reset, ignored restart, mid-dump reset and boundary addresses.
module tb_state_dump_reader;

  localparam int NR = 32;
  localparam int NW = 64;
  localparam int NB = NR + NW;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] dm_raddr;
  logic [31:0] dm_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_tag;
  logic [7:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf_arr [NR];
  logic [31:0] dm_arr [NW];
  logic [31:0] exp_data [NB];
  logic        exp_tag  [NB];
  logic [7:0]  exp_idx  [NB];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Combinational memories answering the DUT's read addresses.
  assign rf_rdata = rf_arr[rf_raddr];
  assign dm_rdata = (dm_raddr < 32'(NW * 4)) ? dm_arr[dm_raddr[7:2]] : 32'hDEAD_BEEF;

  state_dump_reader #(
    .NUM_REGS   (NR),
    .DMEM_WORDS (NW),
    .DATA_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dm_raddr  (dm_raddr),
    .dm_rdata  (dm_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_pattern();
    for (int i = 0; i < NR; i++) rf_arr[i] = 32'(i * 32'h11);
    for (int j = 0; j < NW; j++) dm_arr[j] = 32'hA000_0000 + 32'(j);
  endtask

  task automatic preload_random();
    for (int i = 0; i < NR; i++) rf_arr[i] = $urandom;
    for (int j = 0; j < NW; j++) dm_arr[j] = $urandom;
  endtask

  // mode: 0 always ready, 1 ready toggling, 2 stall 20 cycles at first beat, 3 random ready.
  // restart_at: beat count at which start is pulsed again (-1 none).
  // rst_at: beat count at which reset is asserted mid-dump (-1 none).
  task automatic run_dump(input int mode, input int restart_at, input int rst_at);
    int          acc, cyc, stall_n, bubbles, misal;
    logic        first_seen, prev_stall, exp_done, finished, restarted;
    logic [31:0] h_data, max_dm;
    logic        h_tag, h_last;
    logic [7:0]  h_idx;
    acc = 0; cyc = 0; stall_n = 0; bubbles = 0; misal = 0;
    first_seen = 0; prev_stall = 0; exp_done = 0; finished = 0; restarted = 0;
    h_data = 0; h_tag = 0; h_last = 0; h_idx = 0; max_dm = 0;

    // Expected stream: every register in order, then every memory word in order.
    for (int i = 0; i < NR; i++) begin
      exp_data[i] = rf_arr[i]; exp_tag[i] = 1'b0; exp_idx[i] = 8'(i);
    end
    for (int j = 0; j < NW; j++) begin
      exp_data[NR+j] = dm_arr[j]; exp_tag[NR+j] = 1'b1; exp_idx[NR+j] = 8'(j);
    end

    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);

    while (!finished) begin
      if (cyc >= 3000) begin
        chk("timeout_dump", 64'(acc), 64'(NB));
        finished = 1;
      end else if (rst_at >= 0 && acc == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_index", 64'(out_index), 64'd0);
        chk("rst_async_done", 64'(done), 64'd0);
        tick();
        chk("rst_held_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_after_busy", 64'(busy), 64'd0);
        chk("rst_after_done", 64'(done), 64'd0);
        return;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'(out_data), 64'(h_data));
          chk("stall_tag", 64'(out_tag), 64'(h_tag));
          chk("stall_index", 64'(out_index), 64'(h_idx));
          chk("stall_last", 64'(out_last), 64'(h_last));
        end
        chk("done_pulse", 64'(done), 64'(exp_done));
        if (exp_done) begin
          chk("busy_at_done", 64'(busy), 64'd0);
          finished = 1;
        end else begin
          case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 2 == 0);
            2: begin
              if (out_valid && stall_n < 20) begin
                out_ready = 1'b0;
                stall_n++;
                chk("stall20_index", 64'(out_index), 64'd0);
                chk("stall20_data", 64'(out_data), 64'(rf_arr[0]));
                chk("stall20_busy", 64'(busy), 64'd1);
              end else begin
                out_ready = 1'b1;
              end
            end
            default: out_ready = 1'($urandom_range(0, 1));
          endcase
          if (!restarted && acc == restart_at) begin
            start = 1'b1;
            restarted = 1;
          end else begin
            start = 1'b0;
          end
          if (dm_raddr[1:0] != 2'b00) misal++;
          if (dm_raddr > max_dm) max_dm = dm_raddr;
          if (first_seen && !out_valid) bubbles++;
          if (out_valid) first_seen = 1;
          exp_done = 0;
          if (out_valid && out_ready) begin
            if (acc < NB) begin
              chk("beat_data", 64'(out_data), 64'(exp_data[acc]));
              chk("beat_tag", 64'(out_tag), 64'(exp_tag[acc]));
              chk("beat_index", 64'(out_index), 64'(exp_idx[acc]));
              chk("beat_last", 64'(out_last), 64'(acc == NB - 1));
              chk("beat_busy", 64'(busy), 64'd1);
              if (acc == NR) begin
                chk("first_mem_tag", 64'(out_tag), 64'd1);
                chk("first_mem_index", 64'(out_index), 64'd0);
              end
              if (acc == NB - 1) begin
                chk("final_index", 64'(out_index), 64'(NW - 1));
                exp_done = 1;
              end
              if (mode == 0 && acc == NR - 1) chk("dm_raddr_word0", 64'(dm_raddr), 64'd0);
              if (mode == 0 && acc == NR) chk("dm_raddr_word1", 64'(dm_raddr), 64'd4);
              if (mode == 0 && acc == NB - 2) chk("dm_raddr_lastword", 64'(dm_raddr), 64'hFC);
            end else begin
              chk("extra_beat", 64'(acc), 64'(NB - 1));
            end
            acc++;
          end
          prev_stall = out_valid && !out_ready;
          h_data = out_data; h_tag = out_tag; h_idx = out_index; h_last = out_last;
          tick();
          cyc++;
        end
      end
    end

    start = 1'b0;
    tick();
    chk("done_single_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rf_raddr", 64'(rf_raddr), 64'd0);
    chk("idle_dm_raddr", 64'(dm_raddr), 64'd0);
    chk("beat_count", 64'(acc), 64'(NB));
    chk("dm_raddr_max", 64'(max_dm), 64'hFC);
    chk("dm_raddr_aligned", 64'(misal), 64'd0);
    if (mode == 0) chk("no_bubbles", 64'(bubbles), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    preload_pattern();
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rf_raddr", 64'(rf_raddr), 64'd0);
    chk("rst_dm_raddr", 64'(dm_raddr), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_no_start_valid", 64'(out_valid), 64'd0);
    chk("idle_no_start_busy", 64'(busy), 64'd0);

    // Patterned preload, continuous ready.
    run_dump(0, -1, -1);
    // Same preload, ready alternating.
    run_dump(1, -1, -1);
    // Long stall on the very first beat.
    run_dump(2, -1, -1);
    // Random contents, random ready, extra start while busy.
    preload_random();
    run_dump(3, 10, -1);
    // Reset mid-dump, then a fresh dump must restart at register 0.
    run_dump(0, -1, 40);
    preload_random();
    run_dump(0, -1, -1);
    run_dump(3, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
